stream_rr_arbiter: RTL and testbench
====================================

Name: stream_rr_arbiter

Overview:
- Shares one downstream valid/ready stream between NUM_PORTS upstream requesters. The downstream is typically the two-entry ping-pong handshake buffer.
- Arbitration is round-robin at burst granularity. A grant is held until the granted port delivers a beat with last=1, or until MAX_BURST beats have been accepted.
- Data path is a combinational mux from the granted port. Control (grant, pointer, beat count) is registered.

Parameters:
- NUM_PORTS, 4: number of requesters, 2..16.
- WORD_WIDTH, 32: data width per beat.
- MAX_BURST, 16: beats accepted before a forced release, 2..256.

Ports:
- clk  in  1: clock; all state updates on posedge.
- rst  in  1: asynchronous, active-high reset.
- up_valid  in  NUM_PORTS: per-port valid; bit i = port i.
- up_data  in  NUM_PORTS*WORD_WIDTH: per-port data; port i = bits [i*WORD_WIDTH +: WORD_WIDTH].
- up_last  in  NUM_PORTS: per-port end-of-burst marker.
- up_ready  out  NUM_PORTS: per-port ready.
- down_valid  out  1: muxed valid.
- down_data  out  WORD_WIDTH: muxed data.
- down_last  out  1: muxed last.
- down_ready  in  1: downstream ready.
- grant  out  NUM_PORTS: one-hot registered grant; all zero when idle.
- busy  out  1: 1 while in GRANT state.
- my_transmit  out  1: down_valid & down_ready, one pulse per accepted beat.

Behaviour:

Reset (rst=1, asynchronous):
- state=IDLE, grant=0, rr_ptr=0, beat_cnt=0.
- up_ready, down_valid, down_last, busy and my_transmit read 0 immediately.
- down_data=0.
- An assertion mid-burst abandons the burst with no flush. Arbitration restarts from port 0.

Registers:
- state (IDLE/GRANT).
- gnt_idx, width clog2(NUM_PORTS).
- rr_ptr, width clog2(NUM_PORTS); range 0..NUM_PORTS-1.
- beat_cnt, width clog2(MAX_BURST).

IDLE:
- up_ready=0, down_valid=0, down_data=0, down_last=0.
- If any up_valid bit is set: pick the first set bit scanning from rr_ptr upward, wrapping past NUM_PORTS-1 to 0. Load gnt_idx and grant, go to GRANT.
- Result: one cycle of latency from request to down_valid. No data passes in the decision cycle.

GRANT:
- down_valid=up_valid[gnt_idx], down_data=slice[gnt_idx], down_last=up_last[gnt_idx].
- up_ready[gnt_idx]=down_ready; every other up_ready bit is 0.
- Accepted beat (down_valid & down_ready): beat_cnt increments.
- Release when an accepted beat has down_last=1, or when beat_cnt==MAX_BURST-1 at acceptance. On release:
  - state returns to IDLE, grant clears, beat_cnt returns to 0.
  - rr_ptr becomes gnt_idx+1, wrapping NUM_PORTS-1 to 0.
- The granted port dropping up_valid mid-burst does not release the grant. down_valid falls and the grant is held indefinitely.
- Requests from other ports during GRANT are ignored until release. They do not affect rr_ptr.

Fairness and ordering:
- The just-served port has lowest priority at the next decision. Worst-case wait is NUM_PORTS-1 bursts.
- Minimum idle gap between consecutive bursts: exactly one cycle (the IDLE decision cycle).
- A forced release does not alter last. The downstream sees the continuation as a new burst from the same port when that port is re-granted.

Decomposition:
- Package stream_arb_pkg holds:
  - state enum (ST_IDLE=0, ST_GRANT=1);
  - function rr_pick(req, ptr), returning index and found flag;
  - localparams PTR_W=clog2(NUM_PORTS) and CNT_W=clog2(MAX_BURST).
- One natural sub-module: rr_picker, a combinational masked priority encoder, double-width request vector, wrap-around. Verified standalone.
- The top level holds the FSM, counters and mux.

Test Plan:
- Single port: port 1 sends 3 beats (last on the 3rd), down_ready=1.
  - grant=4'b0010 one cycle after up_valid.
  - down_data matches all 3 beats in order.
  - my_transmit pulses 3 times.
  - After the last beat: grant=0 and rr_ptr=2.
- Round robin: ports 0, 2 and 3 request continuously with 1-beat bursts from reset.
  - Grant order is 0, 2, 3, 0, 2, 3.
  - Each grant is separated by one IDLE cycle.
- Forced release: MAX_BURST=4, port 0 sends 10 beats with last only on the 10th, and port 1 also requests.
  - Port 0 releases after beat 4. Port 1 is granted next, then port 0 resumes at beat 5.
- Backpressure and stall:
  - Toggle down_ready 1010 during a burst: up_ready tracks down_ready on the granted port only, and no beat is duplicated or lost.
  - Drop the granted up_valid for 3 cycles: grant is held, down_valid=0, and beat_cnt is unchanged.
- Reset mid-burst: assert rst during beat 2 of a port-3 burst.
  - Outputs go to 0 in the same cycle, without waiting for clk.
  - After deassertion with ports 1 and 3 requesting, port 1 wins (rr_ptr=0).
- Wrap-around: NUM_PORTS=3, rr_ptr=2, only port 0 requesting.
  - Port 0 is granted.
  - After release, rr_ptr=1.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the stream round-robin arbiter.
package stream_arb_pkg;

   localparam int NUM_PORTS_DEF = 4;
   localparam int MAX_BURST_DEF = 16;
   localparam int PTR_W         = $clog2(NUM_PORTS_DEF);
   localparam int CNT_W         = $clog2(MAX_BURST_DEF);

   // Widest supported requester set; rr_pick works on this width and
   // callers zero-extend narrower request vectors.
   localparam int PORTS_MAX = 16;
   localparam int IDX_MAX_W = 4;
   localparam int POS_W     = IDX_MAX_W + 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic                 found;
      logic [IDX_MAX_W-1:0] idx;
   } rr_pick_t;

   // Round-robin pick over the first n requesters: the request vector is
   // doubled so a scan starting at ptr wraps past n-1 back to 0 naturally.
   function automatic rr_pick_t rr_pick(input logic [PORTS_MAX-1:0] req,
                                        input logic [IDX_MAX_W-1:0] ptr,
                                        input int                   n);
      logic [2*PORTS_MAX-1:0] dbl;
      logic [POS_W-1:0]       pos;
      rr_pick_t               res;
      dbl = '0;
      res = '0;
      for (int i = 0; i < PORTS_MAX; i++) begin
         if (i < n) begin
            dbl[POS_W'(i)]     = req[IDX_MAX_W'(i)];
            dbl[POS_W'(i + n)] = req[IDX_MAX_W'(i)];
         end
      end
      for (int k = 0; k < PORTS_MAX; k++) begin
         pos = {1'b0, ptr} + POS_W'(k);
         if ((k < n) && !res.found && dbl[pos]) begin
            res.found = 1'b1;
            res.idx   = (pos >= POS_W'(n)) ? IDX_MAX_W'(pos - POS_W'(n))
                                           : IDX_MAX_W'(pos);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping back to port 0.
module rr_picker
   import stream_arb_pkg::*;
#(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] idx
);

   logic [PORTS_MAX-1:0] req_ext;
   logic [IDX_MAX_W-1:0] ptr_ext;
   rr_pick_t             pick;

   // Widen to the package scan width and narrow the result back.
   always_comb begin
      req_ext          = '0;
      req_ext[N-1:0]   = req;
      ptr_ext          = '0;
      ptr_ext[W-1:0]   = ptr;
      pick             = rr_pick(req_ext, ptr_ext, N);
      found            = pick.found;
      idx              = W'(pick.idx);
   end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Burst-granular round-robin arbiter sharing one valid/ready stream
// between NUM_PORTS requesters. Data path is a combinational mux from the
// granted port; grant, pointer and beat count are registered.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no grant; decide next port from rr_ptr, nothing passes
//   ST_GRANT | gnt_idx owns the stream until last beat or MAX_BURST beats
module stream_rr_arbiter
   import stream_arb_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int WORD_WIDTH = 32,
   parameter int MAX_BURST  = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            up_valid,
   input  logic [NUM_PORTS*WORD_WIDTH-1:0] up_data,
   input  logic [NUM_PORTS-1:0]            up_last,
   output logic [NUM_PORTS-1:0]            up_ready,
   output logic                            down_valid,
   output logic [WORD_WIDTH-1:0]           down_data,
   output logic                            down_last,
   input  logic                            down_ready,
   output logic [NUM_PORTS-1:0]            grant,
   output logic                            busy,
   output logic                            my_transmit
);

   localparam int                IDX_W     = $clog2(NUM_PORTS);
   localparam int                BCNT_W    = $clog2(MAX_BURST);
   localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0]  LAST_PORT = IDX_W'(NUM_PORTS - 1);

   arb_state_t           state;
   logic [IDX_W-1:0]     gnt_idx;
   logic [IDX_W-1:0]     rr_ptr;
   logic [BCNT_W-1:0]    beat_cnt;
   logic                 pick_found;
   logic [IDX_W-1:0]     pick_idx;
   logic [NUM_PORTS-1:0] pick_onehot;
   logic                 accept;
   logic                 release_now;

   rr_picker #(
      .N (NUM_PORTS),
      .W (IDX_W)
   ) u_picker (
      .req   (up_valid),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Stream mux: only the granted port sees ready, everything else is quiet.
   always_comb begin
      up_ready   = '0;
      down_valid = 1'b0;
      down_data  = '0;
      down_last  = 1'b0;
      if (state == ST_GRANT) begin
         down_valid        = up_valid[gnt_idx];
         down_data         = up_data[gnt_idx*WORD_WIDTH +: WORD_WIDTH];
         down_last         = up_last[gnt_idx];
         up_ready[gnt_idx] = down_ready;
      end
   end

   // Handshake decode; a forced release never touches down_last.
   always_comb begin
      pick_onehot           = '0;
      pick_onehot[pick_idx] = 1'b1;
      accept                = down_valid & down_ready;
      release_now           = accept & (down_last | (beat_cnt == LAST_BEAT));
      my_transmit           = accept;
      busy                  = (state == ST_GRANT);
   end

   // Arbitration FSM with registered grant, pointer and beat count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         gnt_idx  <= '0;
         grant    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  state    <= ST_GRANT;
                  gnt_idx  <= pick_idx;
                  grant    <= pick_onehot;
                  beat_cnt <= '0;
               end
            end
            ST_GRANT: begin
               if (release_now) begin
                  state    <= ST_IDLE;
                  grant    <= '0;
                  beat_cnt <= '0;
                  rr_ptr   <= (gnt_idx == LAST_PORT) ? '0 : gnt_idx + 1'b1;
               end else if (accept) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter (4-port MAX_BURST=4 and 3-port
// instances) plus a few standalone rr_picker vectors.
module tb_stream_rr_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 4-port instance, short forced-release limit
   logic [3:0]   v4, l4, r4, g4;
   logic [127:0] d4;
   logic         dv4, dl4, dr4, b4, t4;
   logic [31:0]  dd4;

   stream_rr_arbiter #(.NUM_PORTS(4), .WORD_WIDTH(32), .MAX_BURST(4)) dut4 (
      .clk(clk), .rst(rst),
      .up_valid(v4), .up_data(d4), .up_last(l4), .up_ready(r4),
      .down_valid(dv4), .down_data(dd4), .down_last(dl4), .down_ready(dr4),
      .grant(g4), .busy(b4), .my_transmit(t4)
   );

   // 3-port instance for pointer wrap
   logic [2:0]  v3, l3, r3, g3;
   logic [95:0] d3;
   logic        dv3, dl3, dr3, b3, t3;
   logic [31:0] dd3;

   stream_rr_arbiter #(.NUM_PORTS(3), .WORD_WIDTH(32), .MAX_BURST(16)) dut3 (
      .clk(clk), .rst(rst),
      .up_valid(v3), .up_data(d3), .up_last(l3), .up_ready(r3),
      .down_valid(dv3), .down_data(dd3), .down_last(dl3), .down_ready(dr3),
      .grant(g3), .busy(b3), .my_transmit(t3)
   );

   // standalone picker
   logic [3:0] pk_req;
   logic [1:0] pk_ptr, pk_idx;
   logic       pk_found;

   rr_picker #(.N(4), .W(2)) u_pick (
      .req(pk_req), .ptr(pk_ptr), .found(pk_found), .idx(pk_idx)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic drive4(input int p, input logic v, input logic [31:0] d, input logic l);
      v4[p]           = v;
      d4[p*32 +: 32]  = d;
      l4[p]           = l;
   endtask

   task automatic drive3(input int p, input logic v, input logic [31:0] d, input logic l);
      v3[p]           = v;
      d3[p*32 +: 32]  = d;
      l3[p]           = l;
   endtask

   // Leaves the caller at a negedge with rst just released (an IDLE cycle).
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      v4 = '0; l4 = '0; d4 = '0; dr4 = 1'b1;
      v3 = '0; l3 = '0; d3 = '0; dr3 = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [3:0]  pk_req_t [5] = '{4'b0000, 4'b1001, 4'b0001, 4'b0110, 4'b1111};
   logic [1:0]  pk_ptr_t [5] = '{2'd2,    2'd1,    2'd3,    2'd2,    2'd0};
   logic        pk_fnd_t [5] = '{1'b0,    1'b1,    1'b1,    1'b1,    1'b1};
   logic [1:0]  pk_idx_t [5] = '{2'd0,    2'd3,    2'd0,    2'd2,    2'd0};

   logic [3:0]  exp_rr [12] = '{4'h0, 4'h1, 4'h0, 4'h4, 4'h0, 4'h8,
                                4'h0, 4'h1, 4'h0, 4'h4, 4'h0, 4'h8};

   logic [3:0]  exp_fg [16] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h0,
                                4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0};
   logic [31:0] exp_fd [16] = '{0, 1, 2, 3, 4, 0, 32'h100, 0,
                                5, 6, 7, 8, 0, 9, 10, 0};

   logic        bp_rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [3:0]  bp_ur  [6] = '{4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h4};
   logic [31:0] bp_dd  [6] = '{0, 32'h20, 32'h21, 32'h21, 32'h22, 32'h22};

   logic [31:0] acc_q [$];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int tx;
      int k;
      int j;
      logic p1_sent;

      rst = 1'b1;
      v4 = '0; l4 = '0; d4 = '0; dr4 = 1'b1;
      v3 = '0; l3 = '0; d3 = '0; dr3 = 1'b1;
      pk_req = '0; pk_ptr = '0;

      // reset state
      @(negedge clk); #1;
      check("rst_grant", g4, 4'h0);
      check("rst_busy", b4, 1'b0);
      check("rst_dvalid", dv4, 1'b0);
      check("rst_uready", r4, 4'h0);
      check("rst_ddata", dd4, 32'h0);
      check("rst_rr_ptr", dut4.rr_ptr, 2'd0);
      check("rst_beat_cnt", dut4.beat_cnt, 2'd0);

      // picker standalone
      for (int i = 0; i < 5; i++) begin
         pk_req = pk_req_t[i];
         pk_ptr = pk_ptr_t[i];
         #1;
         check($sformatf("pick_found_%0d", i), pk_found, pk_fnd_t[i]);
         if (pk_fnd_t[i]) check($sformatf("pick_idx_%0d", i), pk_idx, pk_idx_t[i]);
      end

      // single port, 3-beat burst on port 1
      @(negedge clk);
      rst = 1'b0;
      tx  = 0;
      drive4(1, 1'b1, 32'hA0, 1'b0);
      #1;
      check("sp_decide_grant", g4, 4'h0);
      check("sp_decide_dvalid", dv4, 1'b0);
      @(negedge clk); #1;
      check("sp_grant", g4, 4'b0010);
      check("sp_uready", r4, 4'b0010);
      check("sp_beat0", dd4, 32'hA0);
      if (t4) tx++;
      @(negedge clk);
      drive4(1, 1'b1, 32'hA1, 1'b0);
      #1;
      check("sp_beat1", dd4, 32'hA1);
      if (t4) tx++;
      @(negedge clk);
      drive4(1, 1'b1, 32'hA2, 1'b1);
      #1;
      check("sp_beat2", dd4, 32'hA2);
      check("sp_last", dl4, 1'b1);
      if (t4) tx++;
      @(negedge clk);
      drive4(1, 1'b0, 32'h0, 1'b0);
      #1;
      check("sp_tx_count", tx, 3);
      check("sp_grant_clear", g4, 4'h0);
      check("sp_rr_ptr", dut4.rr_ptr, 2'd2);
      check("sp_busy", b4, 1'b0);

      // round robin, ports 0/2/3 with single-beat bursts
      do_reset();
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         drive4(0, 1'b1, 32'h100, 1'b1);
         drive4(2, 1'b1, 32'h102, 1'b1);
         drive4(3, 1'b1, 32'h103, 1'b1);
         #1;
         check($sformatf("rr_grant_c%0d", c), g4, exp_rr[c]);
      end

      // forced release after 4 beats, port 1 interleaves
      do_reset();
      k = 1;
      p1_sent = 1'b0;
      for (int c = 0; c < 16; c++) begin
         if (c > 0) @(negedge clk);
         drive4(0, k <= 10, 32'(k), k == 10);
         drive4(1, !p1_sent, 32'h100, 1'b1);
         #1;
         check($sformatf("fr_grant_c%0d", c), g4, exp_fg[c]);
         if (exp_fg[c] != 4'h0) check($sformatf("fr_data_c%0d", c), dd4, exp_fd[c]);
         if (c == 4) check("fr_last_kept", dl4, 1'b0);
         if (t4 && g4[0]) k++;
         if (t4 && g4[1]) p1_sent = 1'b1;
      end

      // backpressure on port 2 with port 3 also requesting
      do_reset();
      j = 0;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         dr4 = bp_rdy[c];
         drive4(2, j < 3, 32'h20 + 32'(j), j == 2);
         drive4(3, 1'b1, 32'h30, 1'b0);
         #1;
         if (c > 0) begin
            check($sformatf("bp_uready_c%0d", c), r4, bp_ur[c]);
            check($sformatf("bp_data_c%0d", c), dd4, bp_dd[c]);
         end
         if (t4) acc_q.push_back(dd4);
         if (t4 && g4[2]) j++;
      end
      check("bp_beats", acc_q.size(), 3);
      for (int i = 0; i < acc_q.size() && i < 3; i++)
         check($sformatf("bp_order_%0d", i), acc_q[i], 32'h20 + 32'(i));

      // stall: port 3 drops valid for 3 cycles mid-burst
      @(negedge clk);
      dr4 = 1'b1;
      drive4(2, 1'b0, 32'h0, 1'b0);
      drive4(3, 1'b1, 32'h30, 1'b0);
      #1;
      check("st_idle_gap", g4, 4'h0);
      @(negedge clk); #1;
      check("st_grant", g4, 4'h8);
      check("st_beat0", dd4, 32'h30);
      check("st_tx0", t4, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drive4(3, 1'b0, 32'h0, 1'b0);
         #1;
         check($sformatf("st_hold_grant_%0d", c), g4, 4'h8);
         check($sformatf("st_hold_dvalid_%0d", c), dv4, 1'b0);
         check($sformatf("st_hold_cnt_%0d", c), dut4.beat_cnt, 2'd1);
      end
      @(negedge clk);
      drive4(3, 1'b1, 32'h31, 1'b1);
      #1;
      check("st_beat1", dd4, 32'h31);
      check("st_tx1", t4, 1'b1);
      @(negedge clk);
      drive4(3, 1'b0, 32'h0, 1'b0);
      #1;
      check("st_release", g4, 4'h0);
      check("st_rr_ptr", dut4.rr_ptr, 2'd0);

      // asynchronous reset during beat 2 of a port-3 burst
      do_reset();
      drive4(3, 1'b1, 32'h40, 1'b0);
      #1;
      @(negedge clk); #1;
      check("ar_grant", g4, 4'h8);
      @(negedge clk);
      drive4(3, 1'b1, 32'h41, 1'b0);
      #1;
      check("ar_beat2", dd4, 32'h41);
      #1;
      rst = 1'b1;
      #1;
      check("ar_async_dvalid", dv4, 1'b0);
      check("ar_async_uready", r4, 4'h0);
      check("ar_async_busy", b4, 1'b0);
      check("ar_async_grant", g4, 4'h0);
      check("ar_async_tx", t4, 1'b0);
      check("ar_async_data", dd4, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive4(1, 1'b1, 32'h50, 1'b1);
      drive4(3, 1'b1, 32'h42, 1'b0);
      #1;
      check("ar_rr_ptr", dut4.rr_ptr, 2'd0);
      check("ar_idle", g4, 4'h0);
      @(negedge clk); #1;
      check("ar_port1_wins", g4, 4'h2);

      // pointer wrap on the 3-port instance
      do_reset();
      drive3(1, 1'b1, 32'h61, 1'b1);
      #1;
      check("wr_idle", g3, 3'b000);
      @(negedge clk); #1;
      check("wr_grant1", g3, 3'b010);
      @(negedge clk);
      drive3(1, 1'b0, 32'h0, 1'b0);
      drive3(0, 1'b1, 32'h60, 1'b1);
      #1;
      check("wr_ptr2", dut3.rr_ptr, 2'd2);
      @(negedge clk); #1;
      check("wr_grant0", g3, 3'b001);
      check("wr_data0", dd3, 32'h60);
      @(negedge clk);
      drive3(0, 1'b0, 32'h0, 1'b0);
      #1;
      check("wr_release", g3, 3'b000);
      check("wr_ptr1", dut3.rr_ptr, 2'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
